// File: rtl/sel_demux3_if.sv
// Valid/ready beat stream with end-of-packet marker, shared by the demux
// input and its three output ports.
interface sel_demux3_if #(
   parameter int DATA_W = 8
);
   logic              vld;
   logic              rdy;
   logic [DATA_W-1:0] data;
   logic              last;

   modport master (output vld, output data, output last, input rdy);
   modport slave  (input vld, input data, input last, output rdy);
endinterface

// File: rtl/sel_demux3.sv
// Packet demultiplexer: one input stream steered to one of three registered
// output slices; the route is chosen on the first beat and held until the last.
module sel_demux3 #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel1,
   input  logic             sel2,
   sel_demux3_if.slave      src,
   sel_demux3_if.master     out0,
   sel_demux3_if.master     out1,
   sel_demux3_if.master     out2,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2,
   output logic             busy
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] LOCK  = 1'b1;
   localparam logic [1:0] PORT0 = 2'd0;
   localparam logic [1:0] PORT1 = 2'd1;
   localparam logic [1:0] PORT2 = 2'd2;

   logic [0:0]        state_q, state_d;
   logic [1:0]        route_q, route_d;
   logic [1:0]        routeNow;
   logic [1:0]        target;
   logic [2:0]        slotVld_q, slotVld_d;
   logic [2:0]        slotLast_q, slotLast_d;
   logic [DATA_W-1:0] slotData_q [3];
   logic [DATA_W-1:0] slotData_d [3];
   logic [CNT_W-1:0]  pktCnt_q [3];
   logic [CNT_W-1:0]  pktCnt_d [3];
   logic [2:0]        outRdy;
   logic [2:0]        load;
   logic [2:0]        drain;
   logic              inRdy;
   logic              accept;

   always_comb begin
      if (!sel1) begin
         routeNow = PORT2;
      end else if (sel2) begin
         routeNow = PORT0;
      end else begin
         routeNow = PORT1;
      end
   end

   // Only the slice the current beat is heading for may stall the producer.
   assign target = (state_q == LOCK) ? route_q : routeNow;
   assign outRdy = {out2.rdy, out1.rdy, out0.rdy};
   assign inRdy  = ~rst & (~slotVld_q[target] | outRdy[target]);
   assign accept = src.vld & inRdy;
   assign src.rdy = inRdy;

   always_comb begin
      state_d = state_q;
      route_d = route_q;
      if (accept) begin
         case (state_q)
            IDLE: begin
               if (!src.last) begin
                  state_d = LOCK;
                  route_d = routeNow;
               end
            end
            LOCK: begin
               if (src.last) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // A load and a drain in the same cycle keep the slice full for back-to-back beats.
   always_comb begin
      load       = '0;
      drain      = '0;
      slotVld_d  = slotVld_q;
      slotLast_d = slotLast_q;
      for (int n = 0; n < 3; n++) begin
         slotData_d[n] = slotData_q[n];
         load[n]       = accept & (target == 2'(n));
         drain[n]      = slotVld_q[n] & outRdy[n];
         if (load[n]) begin
            slotVld_d[n]  = 1'b1;
            slotData_d[n] = src.data;
            slotLast_d[n] = src.last;
         end else if (drain[n]) begin
            slotVld_d[n] = 1'b0;
         end
         pktCnt_d[n] = pktCnt_q[n] + CNT_W'(drain[n] & slotLast_q[n]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         route_q    <= PORT0;
         slotVld_q  <= '0;
         slotLast_q <= '0;
         for (int n = 0; n < 3; n++) begin
            slotData_q[n] <= '0;
            pktCnt_q[n]   <= '0;
         end
      end else begin
         state_q    <= state_d;
         route_q    <= route_d;
         slotVld_q  <= slotVld_d;
         slotLast_q <= slotLast_d;
         for (int n = 0; n < 3; n++) begin
            slotData_q[n] <= slotData_d[n];
            pktCnt_q[n]   <= pktCnt_d[n];
         end
      end
   end

   assign out0.vld  = slotVld_q[0];
   assign out0.data = slotData_q[0];
   assign out0.last = slotLast_q[0];
   assign out1.vld  = slotVld_q[1];
   assign out1.data = slotData_q[1];
   assign out1.last = slotLast_q[1];
   assign out2.vld  = slotVld_q[2];
   assign out2.data = slotData_q[2];
   assign out2.last = slotLast_q[2];

   assign cnt0 = pktCnt_q[0];
   assign cnt1 = pktCnt_q[1];
   assign cnt2 = pktCnt_q[2];
   assign busy = (state_q == LOCK);

endmodule

// File: tb/tb_sel_demux3.sv
// Directed bench for sel_demux3: vector table for single-beat routing, plus
// hand sequences for route lock, backpressure, independence, throughput, reset and wrap.
module tb_sel_demux3;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 2;

   logic             clk;
   logic             rst;
   logic             sel1;
   logic             sel2;
   logic [CNT_W-1:0] cnt0, cnt1, cnt2;
   logic             busy;

   sel_demux3_if #(.DATA_W(DATA_W)) src ();
   sel_demux3_if #(.DATA_W(DATA_W)) o0 ();
   sel_demux3_if #(.DATA_W(DATA_W)) o1 ();
   sel_demux3_if #(.DATA_W(DATA_W)) o2 ();

   sel_demux3 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .rst  (rst),
      .sel1 (sel1),
      .sel2 (sel2),
      .src  (src),
      .out0 (o0),
      .out1 (o1),
      .out2 (o2),
      .cnt0 (cnt0),
      .cnt1 (cnt1),
      .cnt2 (cnt2),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       s1;
      logic       s2;
      logic [7:0] data;
      int         port;
   } vec_t;

   vec_t vecs [4];
   int   compared   = 0;
   int   mismatched = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic s1, input logic s2,
                                input logic [7:0] d, input logic l);
      src.vld  = v;
      sel1     = s1;
      sel2     = s2;
      src.data = d;
      src.last = l;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic portVld(input int p);
      case (p)
         0:       return o0.vld;
         1:       return o1.vld;
         default: return o2.vld;
      endcase
   endfunction

   function automatic logic [7:0] portData(input int p);
      case (p)
         0:       return o0.data;
         1:       return o1.data;
         default: return o2.data;
      endcase
   endfunction

   function automatic logic portLast(input int p);
      case (p)
         0:       return o0.last;
         1:       return o1.last;
         default: return o2.last;
      endcase
   endfunction

   initial begin
      logic stray;

      vecs[0] = '{s1: 1'b1, s2: 1'b1, data: 8'hA1, port: 0};
      vecs[1] = '{s1: 1'b1, s2: 1'b0, data: 8'hB2, port: 1};
      vecs[2] = '{s1: 1'b0, s2: 1'b0, data: 8'hC3, port: 2};
      vecs[3] = '{s1: 1'b0, s2: 1'b1, data: 8'hD4, port: 2};

      rst    = 1'b1;
      o0.rdy = 1'b1;
      o1.rdy = 1'b1;
      o2.rdy = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 1'b1);
      tick();
      tick();
      $display("[TB] reset state");
      checkOutput("rst in_rdy", src.rdy, 0);
      checkOutput("rst vld", {o2.vld, o1.vld, o0.vld}, 0);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst cnt", {cnt2, cnt1, cnt0}, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      tick();

      $display("[TB] single-beat routing");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, vecs[i].s1, vecs[i].s2, vecs[i].data, 1'b1);
         checkOutput("t1 in_rdy", src.rdy, 1);
         tick();
         checkOutput("t1 vld mask", {o2.vld, o1.vld, o0.vld}, 32'(3'b001 << vecs[i].port));
         checkOutput("t1 data", portData(vecs[i].port), vecs[i].data);
         checkOutput("t1 last", portLast(vecs[i].port), 1);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      checkOutput("t1 drained", {o2.vld, o1.vld, o0.vld}, 0);
      checkOutput("t1 cnt0", cnt0, 1);
      checkOutput("t1 cnt1", cnt1, 1);
      checkOutput("t1 cnt2", cnt2, 2);

      $display("[TB] route lock");
      stray = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, (i == 0) ? 1'b1 : logic'(i[0]), (i == 0) ? 1'b1 : logic'(i[1]),
                       8'h10 + 8'(i), (i == 3));
         checkOutput("t2 busy", busy, (i != 0));
         tick();
         stray = stray | o1.vld | o2.vld;
         checkOutput("t2 out0 vld", o0.vld, 1);
         checkOutput("t2 out0 data", o0.data, 8'h10 + 8'(i));
         checkOutput("t2 out0 last", o0.last, (i == 3));
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("t2 busy end", busy, 0);
      tick();
      stray = stray | o1.vld | o2.vld;
      checkOutput("t2 no stray", stray, 0);
      checkOutput("t2 cnt0", cnt0, 2);

      $display("[TB] backpressure");
      o1.rdy = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A, 1'b1);
      tick();
      checkOutput("t3 first vld", o1.vld, 1);
      checkOutput("t3 first data", o1.data, 8'h5A);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h6B, 1'b1);
      checkOutput("t3 stall", src.rdy, 0);
      tick();
      checkOutput("t3 held data", o1.data, 8'h5A);
      checkOutput("t3 held vld", o1.vld, 1);
      checkOutput("t3 still stall", src.rdy, 0);
      o1.rdy = 1'b1;
      #1;
      checkOutput("t3 release", src.rdy, 1);
      tick();
      checkOutput("t3 second data", o1.data, 8'h6B);
      checkOutput("t3 second vld", o1.vld, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      checkOutput("t3 drained", o1.vld, 0);
      checkOutput("t3 cnt1", cnt1, 3);

      $display("[TB] independence");
      o0.rdy = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h88, 1'b1);
      checkOutput("t4 in_rdy", src.rdy, 1);
      tick();
      checkOutput("t4 out2 vld", o2.vld, 1);
      checkOutput("t4 out2 data", o2.data, 8'h88);
      checkOutput("t4 out0 held", {o0.vld, o0.data}, {1'b1, 8'h77});
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      checkOutput("t4 out2 drained", o2.vld, 0);
      checkOutput("t4 out0 still", {o0.vld, o0.data}, {1'b1, 8'h77});
      o0.rdy = 1'b1;
      tick();
      checkOutput("t4 out0 drained", o0.vld, 0);
      checkOutput("t4 cnt0", cnt0, 3);
      checkOutput("t4 cnt2", cnt2, 3);

      $display("[TB] throughput");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 8'h50 + 8'(i), (i == 15));
         checkOutput("t5 in_rdy", src.rdy, 1);
         tick();
         checkOutput("t5 vld", o2.vld, 1);
         checkOutput("t5 data", o2.data, 8'h50 + 8'(i));
         checkOutput("t5 last", o2.last, (i == 15));
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      checkOutput("t5 drained", o2.vld, 0);
      checkOutput("t5 cnt2 wrap", cnt2, 0);
      checkOutput("t5 busy", busy, 0);

      $display("[TB] reset mid-packet and counter wrap");
      applyStimulus(1'b1, 1'b1, 1'b1, 8'hE0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'hE1, 1'b0);
      tick();
      checkOutput("t6 busy before", busy, 1);
      rst = 1'b1;
      #1;
      checkOutput("t6 rst in_rdy", src.rdy, 0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      checkOutput("t6 vld", {o2.vld, o1.vld, o0.vld}, 0);
      checkOutput("t6 busy", busy, 0);
      checkOutput("t6 cnt", {cnt2, cnt1, cnt0}, 0);
      checkOutput("t6 out0 cleared", {o0.data, o0.last}, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h99, 1'b1);
      tick();
      checkOutput("t6 idle route", {o2.vld, o1.vld, o0.vld}, 3'b100);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 8'hF0 + 8'(i), 1'b1);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      checkOutput("t6 cnt0 wrap", cnt0, 1);
      checkOutput("t6 cnt2", cnt2, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
